// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide on operand magnitudes, retiring
// UNROLL bits per CALC cycle, followed by one FIX cycle for sign correction.
// Divide-by-zero and signed overflow bypass the engine and finish in one cycle.
module muldiv_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT3_WIDTH = 3,
    parameter int UNROLL       = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    Start,
    input  logic                    Flush,
    input  logic [FUNCT3_WIDTH-1:0] funct3,
    input  logic [DATA_WIDTH-1:0]   SrcA,
    input  logic [DATA_WIDTH-1:0]   SrcB,
    output logic                    Busy,
    output logic                    Done,
    output logic [DATA_WIDTH-1:0]   Result
);

    localparam int W     = DATA_WIDTH;
    localparam int W2    = 2 * DATA_WIDTH;
    localparam int N     = DATA_WIDTH / UNROLL;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    // Two's-complement negate of a word when neg is set
    function automatic logic [W-1:0] cond_neg_w(input logic [W-1:0] x, input logic neg);
        return neg ? (~x + W'(1)) : x;
    endfunction

    // Two's-complement negate of a double-width product when neg is set
    function automatic logic [W2-1:0] cond_neg_2w(input logic [W2-1:0] x, input logic neg);
        return neg ? (~x + W2'(1)) : x;
    endfunction

    // UNROLL shift-add steps: {hi,lo} holds partial product over the multiplier
    function automatic logic [W2-1:0] mul_iter(input logic [W-1:0] hi,
                                               input logic [W-1:0] lo,
                                               input logic [W-1:0] mcand);
        logic [W-1:0] h;
        logic [W-1:0] l;
        logic [W:0]   sum;
        h = hi;
        l = lo;
        for (int i = 0; i < UNROLL; i++) begin
            sum = {1'b0, h} + (l[0] ? {1'b0, mcand} : '0);
            l   = {sum[0], l[W-1:1]};
            h   = sum[W:1];
        end
        return {h, l};
    endfunction

    // UNROLL restoring-divide steps: hi is the partial remainder, lo shifts
    // the dividend out and the quotient in
    function automatic logic [W2-1:0] div_iter(input logic [W-1:0] hi,
                                               input logic [W-1:0] lo,
                                               input logic [W-1:0] dvsr);
        logic [W-1:0] h;
        logic [W-1:0] l;
        logic [W:0]   r;
        h = hi;
        l = lo;
        for (int i = 0; i < UNROLL; i++) begin
            r = {h, l[W-1]};
            l = {l[W-2:0], 1'b0};
            if (r >= {1'b0, dvsr}) begin
                r    = r - {1'b0, dvsr};
                l[0] = 1'b1;
            end
            h = r[W-1:0];
        end
        return {h, l};
    endfunction

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic             qneg_q, rneg_q;
    logic [W-1:0]     opd_q, hi_q, lo_q, result_q;

    logic [2:0]   op;
    logic         is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic         div_zero, div_ovf, fast;
    logic [W-1:0] a_mag, b_mag, fast_res, fix_res;
    logic [W2-1:0] prod;
    logic         accept, step, fix_en;

    // Operand decode: signedness, magnitudes and the one-cycle special cases
    always_comb begin
        op       = funct3[2:0];
        is_div   = op[2];
        a_sgn    = is_div ? ~op[0] : (op != 3'b011);
        b_sgn    = is_div ? ~op[0] : ~op[1];
        a_neg    = a_sgn & SrcA[W-1];
        b_neg    = b_sgn & SrcB[W-1];
        a_mag    = cond_neg_w(SrcA, a_neg);
        b_mag    = cond_neg_w(SrcB, b_neg);
        div_zero = is_div & (SrcB == '0);
        div_ovf  = is_div & ~op[0] & (SrcA == {1'b1, {(W-1){1'b0}}}) & (&SrcB);
        fast     = div_zero | div_ovf;
        if (div_zero)
            fast_res = op[1] ? SrcA : '1;
        else
            fast_res = op[1] ? '0 : SrcA;
    end

    // Sign correction and word select applied in the FIX cycle
    always_comb begin
        prod = cond_neg_2w({hi_q, lo_q}, qneg_q);
        case (op_q)
            3'b000:                 fix_res = prod[W-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[W2-1:W];
            3'b100, 3'b101:         fix_res = cond_neg_w(lo_q, qneg_q);
            default:                fix_res = cond_neg_w(hi_q, rneg_q);
        endcase
    end

    // Next-state and datapath enables; Flush wins over Start
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        step      = 1'b0;
        fix_en    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (Start && !Flush) begin
                    accept    = 1'b1;
                    state_nxt = fast ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (Flush) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == '0)
                        state_nxt = FIX;
                end
            end
            FIX: begin
                if (Flush) begin
                    state_nxt = IDLE;
                end else begin
                    fix_en    = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end

    // Operand capture, iteration engine and result register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q    <= '0;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            opd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= op;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            opd_q  <= is_div ? b_mag : a_mag;
            lo_q   <= is_div ? a_mag : b_mag;
            hi_q   <= '0;
            cnt_q  <= CNT_W'(N - 1);
            if (fast)
                result_q <= fast_res;
        end else if (step) begin
            {hi_q, lo_q} <= op_q[2] ? div_iter(hi_q, lo_q, opd_q)
                                    : mul_iter(hi_q, lo_q, opd_q);
            cnt_q <= cnt_q - CNT_W'(1);
        end else if (fix_en) begin
            result_q <= fix_res;
        end
    end

    assign Busy   = (state_q == CALC) || (state_q == FIX);
    assign Done   = (state_q == DONE);
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected result and
// latency, a negedge monitor pops and compares on every Done pulse.
module tb_muldiv_unit;

    logic        CLK;
    logic        RST_N;
    logic        Start;
    logic        Flush;
    logic [2:0]  funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        int          start;
        int          lat;
        string       nm;
    } exp_t;

    exp_t sb[$];

    muldiv_unit #(.DATA_WIDTH(32), .FUNCT3_WIDTH(3), .UNROLL(1)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .Start  (Start),
        .Flush  (Flush),
        .funct3 (funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every Done must match the oldest outstanding expectation
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N && Done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(Done), 32'h0);
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_result"}, Result, e.res);
                chk({e.nm, "_latency"}, 32'(cyc - e.start), 32'(e.lat));
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start  = 1'b1;
        funct3 = op;
        SrcA   = a;
        SrcB   = b;
    endtask

    task automatic expect_op(input logic [31:0] r, input int lat, input string nm);
        exp_t e;
        e.res   = r;
        e.start = cyc;
        e.lat   = lat;
        e.nm    = nm;
        sb.push_back(e);
    endtask

    // Drop Start and scramble operands so late sampling would corrupt results
    task automatic release_start();
        Start  = 1'b0;
        SrcA   = $urandom;
        SrcB   = $urandom;
        funct3 = 3'($urandom_range(0, 7));
    endtask

    // Wait (bounded) for a Done pulse, counting Busy cycles on the way
    task automatic wait_done(input string nm, output int busy_cnt);
        int guard;
        busy_cnt = 0;
        guard    = 0;
        while (!Done && guard < 100) begin
            if (Busy) busy_cnt++;
            @(negedge CLK);
            guard++;
        end
        if (!Done) chk({nm, "_timeout"}, 32'(Done), 32'h1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input int lat, input string nm,
                          output int busy_cnt);
        @(negedge CLK);
        drive(op, a, b);
        expect_op(r, lat, nm);
        @(negedge CLK);
        release_start();
        wait_done(nm, busy_cnt);
    endtask

    initial begin
        int bc;
        RST_N  = 1'b0;
        Start  = 1'b0;
        Flush  = 1'b0;
        funct3 = 3'b000;
        SrcA   = '0;
        SrcB   = '0;
        repeat (3) @(negedge CLK);
        chk("reset_busy",   32'(Busy), 32'h0);
        chk("reset_done",   32'(Done), 32'h0);
        chk("reset_result", Result,    32'h0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Normal-latency multiply with Busy window
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7x-3", bc);
        chk("mul_busy_cycles", 32'(bc), 32'd33);

        // High-word multiplies
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min_sq", bc);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_max_sq", bc);
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu_m1", bc);

        // Divides and remainders
        run_op(3'b100, 32'hFFFFFFF9, 32'd2,   32'hFFFFFFFD, 34, "div_-7_2",  bc);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2,   32'hFFFFFFFF, 34, "rem_-7_2",  bc);
        run_op(3'b101, 32'd100,      32'd7,   32'd14,       34, "divu_100_7", bc);
        run_op(3'b111, 32'd100,      32'd7,   32'd2,        34, "remu_100_7", bc);

        // Flush in CALC cycle 10: no Done, Result keeps 2
        @(negedge CLK);
        drive(3'b100, 32'hFFFFFFF9, 32'd2);
        @(negedge CLK);
        release_start();
        repeat (9) @(negedge CLK);
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        chk("flush_busy",   32'(Busy), 32'h0);
        chk("flush_done",   32'(Done), 32'h0);
        chk("flush_result", Result,    32'd2);
        repeat (40) @(negedge CLK);

        // Fast path: divide by zero and signed overflow
        run_op(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, "divu_5_0",  bc);
        run_op(3'b110, 32'd5,        32'd0,        32'd5,        1, "rem_5_0",   bc);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf",   bc);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem_ovf",   bc);

        // Asynchronous reset mid-CALC clears outputs immediately
        @(negedge CLK);
        drive(3'b000, 32'd7, 32'd3);
        @(negedge CLK);
        release_start();
        repeat (5) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("midrst_busy",   32'(Busy), 32'h0);
        chk("midrst_done",   32'(Done), 32'h0);
        chk("midrst_result", Result,    32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (40) @(negedge CLK);

        // Back-to-back accept in DONE, then a Start pulse while Busy is ignored
        @(negedge CLK);
        drive(3'b101, 32'd100, 32'd7);
        expect_op(32'd14, 34, "b2b_first");
        @(negedge CLK);
        release_start();
        wait_done("b2b_first", bc);
        drive(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        expect_op(32'hFFFFFFFE, 34, "b2b_second");
        @(negedge CLK);
        chk("b2b_busy_no_idle", 32'(Busy), 32'h1);
        drive(3'b000, 32'd3, 32'd3);
        @(negedge CLK);
        release_start();
        wait_done("b2b_second", bc);
        repeat (5) @(negedge CLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
